// File: rtl/serial_to_parallel_if.sv
// Handshake bundle between a serial bit source / word consumer and serial_to_parallel.
// The testbench or surrounding logic takes the master side; the converter is the slave.
interface serial_to_parallel_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic                  serial_in;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  busy;
   logic                  frame_err;
   logic                  overrun;
   logic [15:0]           word_cnt;

   modport master (
      output start,
      output serial_in,
      output out_ready,
      input  out_data,
      input  out_valid,
      input  busy,
      input  frame_err,
      input  overrun,
      input  word_cnt
   );

   modport slave (
      input  start,
      input  serial_in,
      input  out_ready,
      output out_data,
      output out_valid,
      output busy,
      output frame_err,
      output overrun,
      output word_cnt
   );
endinterface

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel word assembler with start-framed input, a one-word output buffer
// with valid/ready pop, abort and overrun pulses, and a saturating delivered-word counter.
module serial_to_parallel #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   serial_to_parallel_if.slave bus
);
   localparam int                IDX_W    = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                state, state_next;
   logic [IDX_W-1:0]      bit_idx, bit_idx_next;
   logic [DATA_WIDTH-1:0] shreg, shreg_next;
   logic [DATA_WIDTH-1:0] word;
   logic                  word_done;
   logic                  frame_err_next;
   logic                  load_ok;

   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_valid_q;
   logic                  busy_q;
   logic                  frame_err_q;
   logic                  overrun_q;
   logic [15:0]           word_cnt_q;

   // Shifting in from the proper end puts frame bit k at DATA_WIDTH-1-k (MSB first)
   // or at k (LSB first) once all DATA_WIDTH bits have arrived.
   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                      input logic                  b);
      if (MSB_FIRST)
         return {cur[DATA_WIDTH-2:0], b};
      else
         return {b, cur[DATA_WIDTH-1:1]};
   endfunction

   assign word    = shift_in(shreg, bus.serial_in);
   assign load_ok = !out_valid_q || bus.out_ready;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_next     = state;
      bit_idx_next   = bit_idx;
      shreg_next     = shreg;
      word_done      = 1'b0;
      frame_err_next = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               shreg_next   = shift_in('0, bus.serial_in);
               bit_idx_next = ONE_IDX;
               state_next   = SHIFT;
            end
         end

         SHIFT: begin
            if (bit_idx == LAST_IDX) begin
               // The completing sample closes the word; a start here also seeds the next frame.
               word_done = 1'b1;
               if (bus.start) begin
                  shreg_next   = shift_in('0, bus.serial_in);
                  bit_idx_next = ONE_IDX;
               end else begin
                  shreg_next   = word;
                  bit_idx_next = '0;
                  state_next   = IDLE;
               end
            end else if (bus.start) begin
               frame_err_next = 1'b1;
               shreg_next     = shift_in('0, bus.serial_in);
               bit_idx_next   = ONE_IDX;
            end else begin
               shreg_next   = word;
               bit_idx_next = bit_idx + ONE_IDX;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_idx <= '0;
         // NOTE: the shift register is reset as well; it is only DATA_WIDTH flops and keeps sim X-free.
         shreg   <= '0;
      end else begin
         state   <= state_next;
         bit_idx <= bit_idx_next;
         shreg   <= shreg_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         busy_q      <= (state_next == SHIFT);
         frame_err_q <= frame_err_next;
         overrun_q   <= 1'b0;

         if (word_done) begin
            if (load_ok) begin
               out_data_q  <= word;
               out_valid_q <= 1'b1;
               if (word_cnt_q != 16'hFFFF)
                  word_cnt_q <= word_cnt_q + 16'd1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench: an MSB-first and an LSB-first converter share one serial stimulus;
// each scenario task checks hand-computed words, pulses and counters.
module tb_serial_to_parallel;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic serial_in = 1'b0;
   logic out_ready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   int          valid_edges;
   int          ferr_pulses;
   int          ovr_pulses;
   logic [15:0] prev_cnt;
   logic [7:0]  got_words[$];

   serial_to_parallel_if #(.DATA_WIDTH(8)) bus_m ();
   serial_to_parallel_if #(.DATA_WIDTH(8)) bus_l ();

   assign bus_m.start     = start;
   assign bus_m.serial_in = serial_in;
   assign bus_m.out_ready = out_ready;
   assign bus_l.start     = start;
   assign bus_l.serial_in = serial_in;
   assign bus_l.out_ready = out_ready;

   serial_to_parallel #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk (clk),
      .rst (rst),
      .bus (bus_m)
   );

   serial_to_parallel #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bus_l)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      valid_edges = 0;
      ferr_pulses = 0;
      ovr_pulses  = 0;
      prev_cnt    = 16'd0;
      got_words.delete();
   endtask

   task automatic do_reset(input logic ready);
      rst       = 1'b1;
      start     = 1'b0;
      serial_in = 1'b0;
      out_ready = ready;
      step();
      step();
      rst = 1'b0;
      clear_obs();
   endtask

   // Sends nbits from seq (first bit = seq[nbits-1]); start_mask marks frame starts likewise.
   task automatic drive_bits(input logic [31:0] seq, input int nbits, input logic [31:0] start_mask);
      logic [31:0] s;
      logic [31:0] m;
      s = seq << (32 - nbits);
      m = start_mask << (32 - nbits);
      for (int i = 0; i < nbits; i++) begin
         start     = m[31];
         serial_in = s[31];
         s = s << 1;
         m = m << 1;
         step();
         if (bus_m.out_valid) valid_edges++;
         if (bus_m.frame_err) ferr_pulses++;
         if (bus_m.overrun)   ovr_pulses++;
         if (bus_m.word_cnt != prev_cnt) got_words.push_back(bus_m.out_data);
         prev_cnt = bus_m.word_cnt;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++; if (bus_m.out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus_m.out_data); else n_pass++;
      n_checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_m.out_valid); else n_pass++;
      n_checks++; if (bus_m.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus_m.busy); else n_pass++;
      n_checks++; if (bus_m.word_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", bus_m.word_cnt); else n_pass++;
      n_checks++; if ({bus_m.frame_err, bus_m.overrun} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {bus_m.frame_err, bus_m.overrun}); else n_pass++;
      do_reset(1'b1);
      serial_in = 1'b1;
      step();
      step();
      n_checks++; if (bus_m.busy !== 1'b0) $display("FAIL idle_no_start: busy got %b want 0", bus_m.busy); else n_pass++;
   endtask

   task automatic test_single();
      do_reset(1'b1);
      drive_bits(32'hA5, 8, 32'h80);
      n_checks++; if (bus_m.out_data !== 8'hA5) $display("FAIL single_data: got %h want a5", bus_m.out_data); else n_pass++;
      n_checks++; if (bus_l.out_data !== 8'hA5) $display("FAIL single_lsb_data: got %h want a5", bus_l.out_data); else n_pass++;
      n_checks++; if (valid_edges !== 1) $display("FAIL single_latency: valid edges got %0d want 1", valid_edges); else n_pass++;
      n_checks++; if (bus_m.word_cnt !== 16'd1) $display("FAIL single_cnt: got %0d want 1", bus_m.word_cnt); else n_pass++;
      n_checks++; if (bus_m.busy !== 1'b0) $display("FAIL single_busy: got %b want 0", bus_m.busy); else n_pass++;
      step();
      n_checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL single_pop: valid got %b want 0", bus_m.out_valid); else n_pass++;
      n_checks++; if (bus_m.out_data !== 8'hA5) $display("FAIL single_hold: got %h want a5", bus_m.out_data); else n_pass++;
   endtask

   task automatic test_lsb_first();
      do_reset(1'b1);
      drive_bits(32'hC0, 8, 32'h80);
      n_checks++; if (bus_l.out_data !== 8'h03) $display("FAIL lsb_data: got %h want 03", bus_l.out_data); else n_pass++;
      n_checks++; if (bus_m.out_data !== 8'hC0) $display("FAIL msb_data: got %h want c0", bus_m.out_data); else n_pass++;
      n_checks++; if (bus_l.word_cnt !== 16'd1) $display("FAIL lsb_cnt: got %0d want 1", bus_l.word_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset(1'b1);
      drive_bits(32'h3CC3, 16, 32'h8080);
      n_checks++; if (got_words.size() !== 2) $display("FAIL b2b_words: got %0d want 2", got_words.size()); else n_pass++;
      if (got_words.size() == 2) begin
         n_checks++; if (got_words[0] !== 8'h3C) $display("FAIL b2b_first: got %h want 3c", got_words[0]); else n_pass++;
         n_checks++; if (got_words[1] !== 8'hC3) $display("FAIL b2b_second: got %h want c3", got_words[1]); else n_pass++;
      end
      n_checks++; if (ferr_pulses !== 0) $display("FAIL b2b_frame_err: got %0d pulses want 0", ferr_pulses); else n_pass++;
      n_checks++; if (bus_m.word_cnt !== 16'd2) $display("FAIL b2b_cnt: got %0d want 2", bus_m.word_cnt); else n_pass++;
      n_checks++; if (valid_edges !== 2) $display("FAIL b2b_valid_edges: got %0d want 2", valid_edges); else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      drive_bits(32'h1122, 16, 32'h8080);
      n_checks++; if (bus_m.overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", bus_m.overrun); else n_pass++;
      n_checks++; if (ovr_pulses !== 1) $display("FAIL bp_overrun_count: got %0d want 1", ovr_pulses); else n_pass++;
      n_checks++; if (bus_m.out_data !== 8'h11) $display("FAIL bp_data: got %h want 11", bus_m.out_data); else n_pass++;
      n_checks++; if (bus_m.word_cnt !== 16'd1) $display("FAIL bp_cnt: got %0d want 1", bus_m.word_cnt); else n_pass++;
      step();
      n_checks++; if (bus_m.overrun !== 1'b0) $display("FAIL bp_overrun_pulse: got %b want 0", bus_m.overrun); else n_pass++;
      n_checks++; if (bus_m.out_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", bus_m.out_valid); else n_pass++;
      out_ready = 1'b1;
      step();
      n_checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL bp_drain: valid got %b want 0", bus_m.out_valid); else n_pass++;
      n_checks++; if (bus_m.out_data !== 8'h11) $display("FAIL bp_drain_data: got %h want 11", bus_m.out_data); else n_pass++;
   endtask

   task automatic test_abort();
      do_reset(1'b1);
      drive_bits(32'hF5A, 12, 32'h880);
      n_checks++; if (ferr_pulses !== 1) $display("FAIL abort_frame_err: got %0d pulses want 1", ferr_pulses); else n_pass++;
      n_checks++; if (got_words.size() !== 1) $display("FAIL abort_words: got %0d want 1", got_words.size()); else n_pass++;
      n_checks++; if (valid_edges !== 1) $display("FAIL abort_latency: valid edges got %0d want 1", valid_edges); else n_pass++;
      n_checks++; if (bus_m.out_data !== 8'h5A) $display("FAIL abort_data: got %h want 5a", bus_m.out_data); else n_pass++;
      n_checks++; if (bus_m.word_cnt !== 16'd1) $display("FAIL abort_cnt: got %0d want 1", bus_m.word_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      do_reset(1'b0);
      drive_bits(32'hA5, 8, 32'h80);
      drive_bits(32'h1F, 5, 32'h10);
      n_checks++; if (bus_m.busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b want 1", bus_m.busy); else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      n_checks++; if (bus_m.out_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", bus_m.out_data); else n_pass++;
      n_checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus_m.out_valid); else n_pass++;
      n_checks++; if (bus_m.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus_m.busy); else n_pass++;
      n_checks++; if (bus_m.word_cnt !== 16'd0) $display("FAIL midrst_cnt: got %0d want 0", bus_m.word_cnt); else n_pass++;
      #1;
      rst = 1'b0;
      clear_obs();
      step();
      n_checks++; if (bus_m.busy !== 1'b0) $display("FAIL midrst_no_start: busy got %b want 0", bus_m.busy); else n_pass++;
      drive_bits(32'hFF, 8, 32'h80);
      n_checks++; if (bus_m.out_data !== 8'hFF) $display("FAIL midrst_fresh_data: got %h want ff", bus_m.out_data); else n_pass++;
      n_checks++; if (bus_m.word_cnt !== 16'd1) $display("FAIL midrst_fresh_cnt: got %0d want 1", bus_m.word_cnt); else n_pass++;
   endtask

   initial begin
      #2;
      test_reset();
      test_single();
      test_lsb_first();
      test_back_to_back();
      test_backpressure();
      test_abort();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
